brick_adder_pipe: RTL and testbench
===================================

Name: brick_adder_pipe

Overview:
Parametrised, pipelined successor of the 16-input brick adder tree. It reduces N_BRICK signed brick products per beat through a registered binary adder tree. It then shift-accumulates successive beats, one beat per 2-bit weight/activation slice, into a full-precision dot-product result. It sits between the brick multiplier array and the fusion-unit output buffer, with valid/ready on both sides.

Parameters:
N_BRICK, 16, number of brick products per beat; power of 2, minimum 2
IN_W, 5, width of each signed brick product (range -6..9)
ACC_W, 16, signed accumulator/output width; must be at least IN_W+log2(N_BRICK)+6
SH_W, 3, width of the shift field

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_clear  input  1  synchronous flush of pipeline and accumulator
i_valid  input  1  beat valid
o_ready  output  1  block can accept a beat
i_brick_prod  input  N_BRICK*IN_W  packed signed products; lane j at [j*IN_W +: IN_W]
i_shift  input  SH_W  left-shift applied to this beat's tree sum; legal values 0,2,4,6
i_last  input  1  final beat of the current accumulation
o_valid  output  1  result valid
i_ready  input  1  downstream accepts the result
o_sum  output  ACC_W  signed accumulated result

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous, active-low, on i_rst_n. Reset clears all stage valids, the accumulator, o_valid (0) and o_sum (0). It also clears the "start" flag, which resets to 1. Reset mid-accumulation discards any partial sum.
- Definitions: LV = log2(N_BRICK). TREE_W = IN_W + LV. All additions are signed and sign-extended to the result width of their level. The tree sum never overflows.
- Tree: level L adds pairs from level L-1 and registers the result, L = 1..LV. Level 1 operates on the raw inputs. i_shift and i_last travel with the beat through every stage. Each stage also carries a valid bit.
- Accumulate stage:
  - shifted = sign_ext(tree_sum, ACC_W) <<< shift.
  - acc_next = (start ? 0 : acc) + shifted.
  - When the accumulate stage fires, acc <= acc_next.
  - If last = 1, then o_sum <= acc_next, o_valid <= 1, and start <= 1. Otherwise start <= 0.
- Latency: a beat accepted at edge k reaches the accumulator at edge k+LV. A last beat therefore raises o_valid after edge k+LV (LV+1 edges in total, 5 for N_BRICK=16).
- Throughput: one beat per cycle. Bubbles (i_valid=0) propagate as invalid stages and do not disturb acc.
- Handshake:
  - en = !(o_valid && !i_ready).
  - o_ready = en. This is a combinational path from i_ready to o_ready.
  - When en=0 the whole pipeline, acc and o_sum freeze.
  - A beat is accepted on i_valid && o_ready.
  - o_valid falls on o_valid && i_ready unless a new last beat completes in the same edge. In that case o_sum is replaced and o_valid stays 1.
  - o_sum is stable while o_valid && !i_ready.
- i_clear:
  - Takes priority over everything except reset.
  - Next edge: all stage valids 0, acc 0, start 1, o_valid 0. o_sum is held.
  - Beats presented in the clear cycle are dropped.
- Illegal i_shift values (odd, or greater than 6) are applied as given, with no checking.
- Without the optional feature, accumulator overflow wraps modulo 2^ACC_W.

Optional Feature:
Macro BRICK_ADDER_PIPE_SAT_EN.
- Defined: acc_next is computed at ACC_W+1 bits and saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1] before it is written to acc and o_sum. This adds one sticky output bit, o_sat. o_sat is set when any beat of the current accumulation saturated. It is presented with o_sum, is reset to 0, and is cleared at start of the next accumulation or by i_clear.
- Undefined: arithmetic wraps and the o_sat port is absent.

Test Plan:
- Defaults; one beat, all lanes 9, shift 0, last=1 -> o_valid 5 cycles later, o_sum=144. Repeat with all lanes -6 -> o_sum=-96.
- Two beats back-to-back: all lanes 1 with shift 2 and last=0, then all lanes 1 with shift 0 and last=1 -> single result o_sum=80. A following one-beat job of all lanes 0 -> o_sum=0, confirming start reset.
- Stream of 8 one-beat jobs with i_ready held 0 from the first result for 3 cycles -> o_ready low during the stall, o_sum=first result held stable, then all 8 results delivered in order with none lost or duplicated.
- ACC_W=10, all lanes 9, shift 6, last=1 -> o_sum=0 (9216 wraps) without the macro; o_sum=511 and o_sat=1 with BRICK_ADDER_PIPE_SAT_EN.
- Non-last beat in flight, i_clear pulsed one cycle, then one beat of all lanes 2, shift 0, last=1 -> o_sum=32 (pre-clear beat discarded).
- i_rst_n asserted asynchronously mid-job, between clock edges -> o_valid=0 and o_sum=0 immediately. After release, a fresh job gives the correct sum.

Source files
------------

// File: rtl/brick_adder_pipe.sv
// brick_adder_pipe: registered binary adder tree over N_BRICK signed products, then shift-accumulate per beat.
// Optional macro BRICK_ADDER_PIPE_SAT_EN saturates the accumulator and adds the sticky o_sat output.
module brick_adder_pipe #(
    parameter int N_BRICK = 16,
    parameter int IN_W    = 5,
    parameter int ACC_W   = 16,
    parameter int SH_W    = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [N_BRICK*IN_W-1:0]   i_brick_prod,
    input  logic [SH_W-1:0]           i_shift,
    input  logic                      i_last,
    output logic                      o_valid,
    input  logic                      i_ready,
`ifdef BRICK_ADDER_PIPE_SAT_EN
    output logic                      o_sat,
`endif
    output logic signed [ACC_W-1:0]   o_sum
);
    localparam int LV     = $clog2(N_BRICK);
    localparam int TREE_W = IN_W + LV;

    // Heap layout: node i sums nodes 2i and 2i+1; indices >= N_BRICK are the raw lanes.
    logic signed [TREE_W-1:0] node_q [1:N_BRICK-1];
    logic signed [TREE_W-1:0] node_d [1:N_BRICK-1];
    logic signed [TREE_W-1:0] all_c  [1:2*N_BRICK-1];
    logic [LV:1]              vld_q, vld_d, lst_q, lst_d;
    logic [SH_W-1:0]          sh_q [1:LV];
    logic [SH_W-1:0]          sh_d [1:LV];
    logic signed [ACC_W-1:0]  acc_q, acc_d, sum_q, sum_d, acc_next;
    logic                     start_q, start_d, ov_q, ov_d;
    logic                     en, fire, done;

`ifdef BRICK_ADDER_PIPE_SAT_EN
    // Wide enough that neither the shift nor the add can wrap before saturation.
    localparam int XW = (ACC_W + 1 > TREE_W + (1 << SH_W)) ? ACC_W + 1 : TREE_W + (1 << SH_W);
    localparam logic signed [XW-1:0] MAX_X = {{(XW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_X = ~MAX_X;
    logic signed [XW-1:0] sum_x;
    logic                 stk_q, stk_d, stk_next, osat_q, osat_d;
`endif

    always_comb begin
        en   = !(ov_q && !i_ready);
        fire = en && vld_q[LV];
        done = !i_clear && fire && lst_q[LV];
        for (int i = 1; i < N_BRICK; i++)
            all_c[i] = node_q[i];
        for (int i = 0; i < N_BRICK; i++)
            all_c[N_BRICK+i] = TREE_W'($signed(i_brick_prod[i*IN_W +: IN_W]));
        for (int i = 1; i < N_BRICK; i++)
            node_d[i] = en ? all_c[2*i] + all_c[2*i+1] : node_q[i];
        vld_d[1] = i_clear ? 1'b0 : en ? i_valid : vld_q[1];
        lst_d[1] = en ? i_last : lst_q[1];
        sh_d[1]  = en ? i_shift : sh_q[1];
        for (int l = 2; l <= LV; l++) begin
            vld_d[l] = i_clear ? 1'b0 : en ? vld_q[l-1] : vld_q[l];
            lst_d[l] = en ? lst_q[l-1] : lst_q[l];
            sh_d[l]  = en ? sh_q[l-1] : sh_q[l];
        end
`ifdef BRICK_ADDER_PIPE_SAT_EN
        sum_x    = (start_q ? XW'(0) : XW'(acc_q)) + (XW'(node_q[1]) <<< sh_q[LV]);
        acc_next = sum_x > MAX_X ? MAX_X[ACC_W-1:0] :
                   sum_x < MIN_X ? MIN_X[ACC_W-1:0] : sum_x[ACC_W-1:0];
        stk_next = (!start_q && stk_q) || sum_x > MAX_X || sum_x < MIN_X;
        stk_d    = i_clear ? 1'b0 : fire ? stk_next : stk_q;
        osat_d   = i_clear ? 1'b0 : done ? stk_next : osat_q;
`else
        acc_next = (start_q ? ACC_W'(0) : acc_q) + (ACC_W'(node_q[1]) <<< sh_q[LV]);
`endif
        acc_d   = i_clear ? '0 : fire ? acc_next : acc_q;
        start_d = i_clear ? 1'b1 : fire ? lst_q[LV] : start_q;
        ov_d    = i_clear ? 1'b0 : en ? done : ov_q;
        sum_d   = done ? acc_next : sum_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < N_BRICK; i++)
                node_q[i] <= '0;
            for (int l = 1; l <= LV; l++)
                sh_q[l] <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            start_q <= 1'b1;
            ov_q    <= 1'b0;
`ifdef BRICK_ADDER_PIPE_SAT_EN
            stk_q   <= 1'b0;
            osat_q  <= 1'b0;
`endif
        end else begin
            node_q  <= node_d;
            sh_q    <= sh_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            start_q <= start_d;
            ov_q    <= ov_d;
`ifdef BRICK_ADDER_PIPE_SAT_EN
            stk_q   <= stk_d;
            osat_q  <= osat_d;
`endif
        end
    end

    assign o_ready = en;
    assign o_valid = ov_q;
    assign o_sum   = sum_q;
`ifdef BRICK_ADDER_PIPE_SAT_EN
    assign o_sat   = osat_q;
`endif
endmodule

// File: tb/tb_brick_adder_pipe.sv
// tb_brick_adder_pipe: table-driven vectors and corner sequences, results checked through a scoreboard queue.
module tb_brick_adder_pipe;
    localparam int PW = 80;

    logic clk = 1'b0, rst_n = 1'b0;
    logic i_clear = 1'b0, i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b1;
    logic [PW-1:0] prod = '0;
    logic [2:0] shift = '0;
    logic o_ready, o_valid;
    logic signed [15:0] o_sum;

    logic w_valid = 1'b0, w_ready_o, w_ovalid;
    logic [PW-1:0] w_prod = '0;
    logic signed [9:0] w_sum;
`ifdef BRICK_ADDER_PIPE_SAT_EN
    logic o_sat, w_sat;
`endif

    int n_cmp = 0, n_bad = 0;
    int q[$];

    always #5 clk = ~clk;

    brick_adder_pipe dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
        .i_brick_prod(prod), .i_shift(shift), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
`ifdef BRICK_ADDER_PIPE_SAT_EN
        .o_sat(o_sat),
`endif
        .o_sum(o_sum)
    );

    brick_adder_pipe #(.ACC_W(10)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_valid(w_valid), .o_ready(w_ready_o),
        .i_brick_prod(w_prod), .i_shift(3'd6), .i_last(1'b1), .o_valid(w_ovalid), .i_ready(1'b1),
`ifdef BRICK_ADDER_PIPE_SAT_EN
        .o_sat(w_sat),
`endif
        .o_sum(w_sum)
    );

    typedef struct {
        logic [PW-1:0] p;
        logic [2:0]    s;
        logic          l;
        int            e;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] splat(input int v);
        logic [PW-1:0] r;
        for (int j = 0; j < 16; j++) r[j*5 +: 5] = 5'(v);
        return r;
    endfunction

    function automatic logic [PW-1:0] ramp();
        logic [PW-1:0] r;
        for (int j = 0; j < 16; j++) r[j*5 +: 5] = 5'(j - 6);
        return r;
    endfunction

    function automatic logic [PW-1:0] alt();
        logic [PW-1:0] r;
        for (int j = 0; j < 16; j++) r[j*5 +: 5] = (j % 2 == 0) ? 5'd9 : 5'(-6);
        return r;
    endfunction

    // Present one beat, wait for acceptance and push its result if it closes a job.
    task automatic send(input logic [PW-1:0] p, input logic [2:0] s, input logic l, input int e);
        int t = 0;
        i_valid = 1'b1; prod = p; shift = s; i_last = l;
        @(negedge clk);
        while (!o_ready && t < 50) begin @(negedge clk); t++; end
        if (t == 50) chk("accept_timeout", t, 0);
        if (l) q.push_back(e);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || o_valid) && t < 100) begin @(negedge clk); t++; end
        chk("drain_left", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_result: got %0d expected none at %0t", o_sum, $time);
            end else chk("result", o_sum, q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ov4, ov5, t;
        tbl[0]  = '{splat(9), 3'd0, 1'b1, 144};
        tbl[1]  = '{splat(-6), 3'd0, 1'b1, -96};
        tbl[2]  = '{splat(1), 3'd2, 1'b0, 0};
        tbl[3]  = '{splat(1), 3'd0, 1'b1, 80};
        tbl[4]  = '{splat(0), 3'd0, 1'b1, 0};
        tbl[5]  = '{ramp(), 3'd4, 1'b1, 384};
        tbl[6]  = '{alt(), 3'd6, 1'b0, 0};
        tbl[7]  = '{splat(9), 3'd6, 1'b1, 10752};
        tbl[8]  = '{splat(9), 3'd6, 1'b0, 0};
        tbl[9]  = '{splat(9), 3'd6, 1'b0, 0};
        tbl[10] = '{splat(9), 3'd6, 1'b0, 0};
`ifdef BRICK_ADDER_PIPE_SAT_EN
        tbl[11] = '{splat(9), 3'd6, 1'b1, 32767};
`else
        tbl[11] = '{splat(9), 3'd6, 1'b1, -28672};
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_sum", o_sum, 0);
        chk("rst_o_ready", o_ready, 1);
        @(posedge clk); #1;

        send(tbl[0].p, tbl[0].s, tbl[0].l, tbl[0].e);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 4) ov4 = o_valid;
            if (c == 5) ov5 = o_valid;
        end
        chk("latency_before", ov4, 0);
        chk("latency_at", ov5, 1);
        @(posedge clk); #1;
        for (int i = 1; i < 12; i++) send(tbl[i].p, tbl[i].s, tbl[i].l, tbl[i].e);
        drain();

        // Back-pressure: first result held for three cycles while the stream stalls.
        @(posedge clk); #1;
        i_ready = 1'b0;
        fork
            for (int k = 1; k <= 8; k++) send(splat(k), 3'd0, 1'b1, 16 * k);
            begin
                t = 0;
                while (!o_valid && t < 100) begin @(negedge clk); t++; end
                chk("stall_wait", t < 100, 1);
                for (int c = 0; c < 3; c++) begin
                    chk("stall_o_ready", o_ready, 0);
                    chk("stall_o_sum", o_sum, 16);
                    if (c < 2) @(negedge clk);
                end
                @(posedge clk); #1;
                i_ready = 1'b1;
            end
        join
        drain();

        // Clear drops the beat in flight and the beat offered during the clear cycle.
        @(posedge clk); #1;
        send(splat(5), 3'd0, 1'b0, 0);
        i_clear = 1'b1; i_valid = 1'b1; prod = splat(7); i_last = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0; i_valid = 1'b0;
        send(splat(2), 3'd0, 1'b1, 32);
        drain();

        // Asynchronous reset between edges discards the partial job.
        @(posedge clk); #1;
        chk("pre_rst_o_sum", o_sum, 32);
        send(splat(4), 3'd0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", o_valid, 0);
        chk("async_rst_o_sum", o_sum, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(splat(1), 3'd0, 1'b1, 16);
        drain();

        // Narrow accumulator: 144 << 6 = 9216 overflows ten bits.
        @(posedge clk); #1;
        w_valid = 1'b1; w_prod = splat(9);
        @(posedge clk); #1;
        w_valid = 1'b0;
        t = 0;
        while (!w_ovalid && t < 20) begin @(negedge clk); t++; end
        chk("narrow_valid", w_ovalid, 1);
`ifdef BRICK_ADDER_PIPE_SAT_EN
        chk("narrow_sum", w_sum, 511);
        chk("narrow_sat", w_sat, 1);
`else
        chk("narrow_sum", w_sum, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
